// File: rtl/adder_pkg.sv
// adder_pkg: shared word width, adder latency and FSM encoding
// used by the adder arbiter, the adder and the bench.
package adder_pkg;

  localparam int WIDTH   = 25;
  localparam int LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, first request
// at or after ptr, wrapping to the lowest index.
module rr_arbiter #(
  parameter  int N_REQ = 3,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] pick;

  // mask below ptr, fall back to all, keep lowest set bit
  always_comb begin
    mask  = ~((ONE << ptr) - ONE);
    upper = req & mask;
    pick  = (|upper) ? upper : req;
    gnt   = pick & (~pick + ONE);
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one external adder among N_REQ
// requesters, one operation in flight at a time.
module adder_arbiter #(
  parameter  int N_REQ   = 3,
  parameter  int WIDTH   = adder_pkg::WIDTH,
  parameter  int LATENCY = adder_pkg::LATENCY,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ_VALID,
  output logic [N_REQ-1:0]          REQ_READY,
  input  logic [N_REQ*4*WIDTH-1:0]  REQ_WORDS,
  output logic signed [WIDTH-1:0]   ADD_WORD_0,
  output logic signed [WIDTH-1:0]   ADD_WORD_1,
  output logic signed [WIDTH-1:0]   ADD_WORD_2,
  output logic signed [WIDTH-1:0]   ADD_WORD_3,
  input  logic signed [WIDTH-1:0]   ADD_RES,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [IDW-1:0]            RSP_ID,
  output logic signed [WIDTH-1:0]   RSP_RES,
  output logic                      BUSY
);

  localparam int CW  = $clog2(LATENCY + 1) + 1;
  localparam int OPW = 4 * WIDTH;

  adder_pkg::state_t state;

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gidx;
  logic [IDW-1:0]   nptr;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] gnt;
  logic [OPW-1:0]   gwords;
  logic [OPW-1:0]   words;
  logic             accept;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req (REQ_VALID),
    .ptr (ptr),
    .gnt (gnt)
  );

  // winner index, its operand block and the pointer after it
  always_comb begin
    gidx   = '0;
    gwords = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gidx   = IDW'(i);
        gwords = REQ_WORDS[i*OPW +: OPW];
      end
    end
    if (gidx == IDW'(N_REQ - 1))
      nptr = '0;
    else
      nptr = gidx + IDW'(1);
  end

  assign accept =
    (state == adder_pkg::IDLE) && !RST && (|gnt);

  assign REQ_READY = accept ? gnt : '0;

  assign ADD_WORD_0 = words[0*WIDTH +: WIDTH];
  assign ADD_WORD_1 = words[1*WIDTH +: WIDTH];
  assign ADD_WORD_2 = words[2*WIDTH +: WIDTH];
  assign ADD_WORD_3 = words[3*WIDTH +: WIDTH];

  // control FSM with registered operands and response
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= adder_pkg::IDLE;
      ptr       <= '0;
      cnt       <= '0;
      words     <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_RES   <= '0;
      BUSY      <= 1'b0;
    end else begin
      unique case (state)
        adder_pkg::IDLE: begin
          if (accept) begin
            words  <= gwords;
            RSP_ID <= gidx;
            ptr    <= nptr;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= adder_pkg::WAIT;
          end
        end
        adder_pkg::WAIT: begin
          if (cnt == CW'(LATENCY)) begin
            RSP_RES   <= ADD_RES;
            RSP_VALID <= 1'b1;
            state     <= adder_pkg::RESPOND;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        adder_pkg::RESPOND: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= adder_pkg::IDLE;
          end
        end
        default: begin
          RSP_VALID <= 1'b0;
          BUSY      <= 1'b0;
          state     <= adder_pkg::IDLE;
        end
      endcase
    end
  end

endmodule
